regheap_acc_drain_seq: RTL
==========================

Name: regheap_acc_drain_seq

Overview:
Sequencer and drain stage wrapped around the 64x16b self-add register heap. It accepts ACC_LEN input beats of 1024 bits and forwards them to the heap. It counts the heap's result-valid pulses, snapshots the final accumulated vector, and pulses the heap's user clear. It then serialises the snapshot as 128-bit words on a valid/ready stream to the downstream writer.

Parameters:
ACC_LEN, 16, beats accumulated per group (legal range 1..65535)
LANES, 64, 16-bit lanes per vector
LANE_W, 16, bits per lane
OUT_W, 128, output word width; NBEAT = LANES*LANE_W/OUT_W = 8

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
s_valid  in  1  upstream beat valid
s_ready  out  1  upstream beat accept
s_data  in  1024  upstream beat, lane i = bits [16i+15:16i]
acc_in_v  out  1  to heap data_v
acc_in_data  out  1024  to heap in_data
acc_clr  out  1  to heap usr_rst
acc_out_v  in  1  from heap reg_data_v_w
acc_out_data  in  1024  from heap reg_data_w
m_valid  out  1  output word valid
m_ready  in  1  output word accept
m_data  out  128  output word
m_last  out  1  high on beat NBEAT-1
busy  out  1  high in every state except ACCUM
err  out  1  sticky protocol error

Behaviour:
- Reset (rst=0, asynchronous): state ACCUM. Counters, snapshot and beat index are 0. All outputs are 0, including s_ready. s_ready rises the first clock edge after rst releases.
- All outputs are registered. The only exception is m_data, which is a mux of the snapshot register indexed by the registered beat index.
- ACCUM state:
  - A beat is accepted when s_valid & s_ready.
  - On accept: acc_in_v=1 and acc_in_data=s_data on the next cycle (1-cycle latency); otherwise acc_in_v=0 and acc_in_data holds its value.
  - in_cnt increments per accepted beat.
  - When the accepted beat is number ACC_LEN (in_cnt==ACC_LEN-1), go to WAIT_RES. s_ready is 0 from the next cycle.
- Result counting: out_cnt increments on every acc_out_v in ACCUM or WAIT_RES.
- WAIT_RES state:
  - s_ready=0.
  - When acc_out_v=1 and out_cnt==ACC_LEN-1: capture acc_out_data into the snapshot, then go to CLEAR.
  - The ACC_LEN-th pulse may also arrive while still in ACCUM. That cannot happen in legal operation; if it does, set err. Do not capture.
- CLEAR state:
  - Lasts exactly 1 cycle; acc_clr=1 during it.
  - in_cnt, out_cnt and the beat index are zeroed.
  - Next state DRAIN.
- DRAIN state:
  - m_valid=1.
  - m_data = snapshot[OUT_W*beat +: OUT_W]. Beat 0 carries lanes 0..7, beat 7 carries lanes 56..63.
  - m_last=1 when beat==NBEAT-1.
  - On m_valid & m_ready, beat increments. On the last-beat handshake: m_valid=0, state ACCUM, s_ready=1 next cycle.
  - While m_ready=0, m_data and m_last hold stable.
- Minimum group period: ACC_LEN accept cycles + heap latency + 1 CLEAR cycle + NBEAT drain cycles. Input and drain never overlap.
- No arithmetic is done here. Data passes bit-exact, with no reordering or sign handling.
- err is sticky until reset. It sets on either of:
  - acc_out_v=1 in CLEAR or DRAIN;
  - out_cnt reaching ACC_LEN while state is ACCUM.
  Setting err does not change the FSM.
- Edge case ACC_LEN=1: the first accepted beat goes directly to WAIT_RES.
- Simultaneous s_valid during WAIT_RES, CLEAR or DRAIN: ignored, because s_ready=0. Upstream must hold the beat.
- Reset mid-operation: snapshot and partial group are discarded. The heap shares rst and is cleared by it. acc_clr is not pulsed.

Test Plan:
1. ACC_LEN=4; feed 4 back-to-back beats with lane i = i+1, heap model attached → after the CLEAR pulse, 8 output words. Word 0 lanes = 4,8,...,32. Word 7 lanes = 228..256 step 4. m_last only on word 7. acc_clr is high exactly 1 cycle.
2. Same group with m_ready toggling 1/0 every cycle → m_data holds while m_ready=0. Exactly 8 handshakes. s_ready returns 1 one cycle after the last handshake.
3. ACC_LEN=1; single beat of lane value 0x7FFF → s_ready drops the next cycle. All 8 words carry 0x7FFF in every lane.
4. s_valid held high across 2 groups (ACC_LEN=4) → exactly 4 beats accepted per group. s_ready=0 throughout WAIT_RES, CLEAR and DRAIN. The second group's results are independent of the first, proving the clear works.
5. Assert rst low at drain word 3 → all outputs 0 asynchronously, no further m_valid. After release: ACCUM state, s_ready=1, err=0.
6. Inject an extra acc_out_v during DRAIN → err=1 and stays 1. The drain completes normally with unchanged data.

Source files
------------

// File: rtl/regheap_acc_drain_seq.sv
// Sequencer and drain stage for the 64x16b self-add register heap: feeds ACC_LEN beats,
// waits for the final accumulated vector, clears the heap and streams the snapshot out.
module regheap_acc_drain_seq #(
   parameter int ACC_LEN = 16,
   parameter int LANES   = 64,
   parameter int LANE_W  = 16,
   parameter int OUT_W   = 128
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [LANES*LANE_W-1:0]   s_data,
   output logic                      acc_in_v,
   output logic [LANES*LANE_W-1:0]   acc_in_data,
   output logic                      acc_clr,
   input  logic                      acc_out_v,
   input  logic [LANES*LANE_W-1:0]   acc_out_data,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [OUT_W-1:0]          m_data,
   output logic                      m_last,
   output logic                      busy,
   output logic                      err
);

   localparam int VecW  = LANES * LANE_W;
   localparam int NBEAT = VecW / OUT_W;
   localparam int BeatW = (NBEAT > 1) ? $clog2(NBEAT) : 1;

   localparam logic [15:0]      InLast   = 16'(ACC_LEN - 1);
   localparam logic [16:0]      OutLast  = 17'(ACC_LEN - 1);
   localparam logic [BeatW-1:0] BeatLast = BeatW'(NBEAT - 1);

   typedef enum logic [1:0] {
      ACCUM    = 2'd0,
      WAIT_RES = 2'd1,
      CLEAR    = 2'd2,
      DRAIN    = 2'd3
   } state_e;

   state_e                   state_q;
   logic [15:0]              in_cnt_q;
   logic [15:0]              in_cnt_d;
   logic [16:0]              out_cnt_q;
   logic [16:0]              out_cnt_d;
   logic [BeatW-1:0]         beat_q;
   logic [VecW-1:0]          snap_q;
   logic                     s_ready_q;
   logic                     acc_in_v_q;
   logic [VecW-1:0]          acc_in_data_q;
   logic                     acc_clr_q;
   logic                     m_valid_q;
   logic                     m_last_q;
   logic                     busy_q;
   logic                     err_q;
   logic                     in_fire;
   logic [NBEAT-1:0][OUT_W-1:0] snap_words;

   assign in_fire   = s_valid && s_ready_q;
   assign in_cnt_d  = in_cnt_q + 16'd1;
   assign out_cnt_d = acc_out_v ? (out_cnt_q + 17'd1) : out_cnt_q;

   // The snapshot is viewed as NBEAT output words; beat 0 holds the lowest lanes.
   assign snap_words = snap_q;
   assign m_data     = snap_words[beat_q];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ACCUM;
         in_cnt_q      <= '0;
         out_cnt_q     <= '0;
         beat_q        <= '0;
         snap_q        <= '0;
         s_ready_q     <= 1'b0;
         acc_in_v_q    <= 1'b0;
         acc_in_data_q <= '0;
         acc_clr_q     <= 1'b0;
         m_valid_q     <= 1'b0;
         m_last_q      <= 1'b0;
         busy_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         acc_in_v_q <= 1'b0;
         acc_clr_q  <= 1'b0;

         // Heap results outside the accumulate window, or one result too many, are flagged only.
         if ((state_q == CLEAR || state_q == DRAIN) && acc_out_v) begin
            err_q <= 1'b1;
         end
         if (state_q == ACCUM && acc_out_v && out_cnt_q >= OutLast) begin
            err_q <= 1'b1;
         end

         unique case (state_q)
            ACCUM: begin
               s_ready_q <= 1'b1;
               busy_q    <= 1'b0;
               out_cnt_q <= out_cnt_d;
               if (in_fire) begin
                  acc_in_v_q    <= 1'b1;
                  acc_in_data_q <= s_data;
                  in_cnt_q      <= in_cnt_d;
                  if (in_cnt_q == InLast) begin
                     state_q   <= WAIT_RES;
                     s_ready_q <= 1'b0;
                     busy_q    <= 1'b1;
                  end
               end
            end

            WAIT_RES: begin
               out_cnt_q <= out_cnt_d;
               if (acc_out_v && out_cnt_q == OutLast) begin
                  snap_q    <= acc_out_data;
                  state_q   <= CLEAR;
                  acc_clr_q <= 1'b1;
               end
            end

            CLEAR: begin
               in_cnt_q  <= '0;
               out_cnt_q <= '0;
               beat_q    <= '0;
               state_q   <= DRAIN;
               m_valid_q <= 1'b1;
               m_last_q  <= (NBEAT == 1);
            end

            DRAIN: begin
               if (m_valid_q && m_ready) begin
                  if (beat_q == BeatLast) begin
                     m_valid_q <= 1'b0;
                     m_last_q  <= 1'b0;
                     beat_q    <= '0;
                     state_q   <= ACCUM;
                     s_ready_q <= 1'b1;
                     busy_q    <= 1'b0;
                  end else begin
                     beat_q   <= beat_q + 1'b1;
                     m_last_q <= ((beat_q + 1'b1) == BeatLast);
                  end
               end
            end
         endcase
      end
   end

   assign s_ready     = s_ready_q;
   assign acc_in_v    = acc_in_v_q;
   assign acc_in_data = acc_in_data_q;
   assign acc_clr     = acc_clr_q;
   assign m_valid     = m_valid_q;
   assign m_last      = m_last_q;
   assign busy        = busy_q;
   assign err         = err_q;

endmodule
